// File: rtl/lynx_kbd_pkg.sv
// Shared definitions for the PS/2 to Lynx keyboard matrix bridge:
// scancode constants, prefix state, keymap entry type and the keymap table.
package lynx_kbd_pkg;

  localparam logic [7:0] E0 = 8'hE0;
  localparam logic [7:0] F0 = 8'hF0;
  localparam logic [7:0] AA = 8'hAA;
  localparam logic [7:0] FC = 8'hFC;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} pfx_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } keymap_entry_t;

  function automatic keymap_entry_t km(input logic [3:0] r, input logic [2:0] c);
    keymap_entry_t e;
    e.valid = 1'b1;
    e.row   = r;
    e.col   = c;
    return e;
  endfunction

  // Self-test pass, keyboard error and overrun bytes all mean the keyboard
  // state is unknown, so the whole matrix is dropped.
  function automatic logic is_clear_code(input logic [7:0] c);
    return (c == AA) || (c == FC) || (c == 8'h00) || (c == 8'hFF);
  endfunction

  function automatic keymap_entry_t keymap_lookup(input logic ext, input logic [7:0] c);
    keymap_entry_t e;
    e = '0;
    if (!ext) begin
      case (c)
        8'h12, 8'h59: e = km(4'd0, 3'd0);
        8'h15: e = km(4'd1, 3'd0);
        8'h1D: e = km(4'd1, 3'd1);
        8'h24: e = km(4'd1, 3'd2);
        8'h2D: e = km(4'd1, 3'd3);
        8'h2C: e = km(4'd1, 3'd4);
        8'h35: e = km(4'd1, 3'd5);
        8'h3C: e = km(4'd1, 3'd6);
        8'h43: e = km(4'd1, 3'd7);
        8'h44: e = km(4'd2, 3'd0);
        8'h4D: e = km(4'd2, 3'd1);
        8'h16: e = km(4'd2, 3'd2);
        8'h1E: e = km(4'd2, 3'd3);
        8'h26: e = km(4'd2, 3'd4);
        8'h25: e = km(4'd2, 3'd5);
        8'h2E: e = km(4'd2, 3'd6);
        8'h36: e = km(4'd2, 3'd7);
        8'h1B: e = km(4'd3, 3'd0);
        8'h23: e = km(4'd3, 3'd1);
        8'h2B: e = km(4'd3, 3'd2);
        8'h34: e = km(4'd3, 3'd3);
        8'h1C: e = km(4'd3, 3'd4);
        8'h33: e = km(4'd3, 3'd5);
        8'h3B: e = km(4'd3, 3'd6);
        8'h42: e = km(4'd3, 3'd7);
        8'h4B: e = km(4'd4, 3'd0);
        8'h1A: e = km(4'd4, 3'd1);
        8'h22: e = km(4'd4, 3'd2);
        8'h21: e = km(4'd4, 3'd3);
        8'h2A: e = km(4'd4, 3'd4);
        8'h32: e = km(4'd4, 3'd5);
        8'h31: e = km(4'd4, 3'd6);
        8'h3A: e = km(4'd4, 3'd7);
        8'h3D: e = km(4'd5, 3'd0);
        8'h3E: e = km(4'd5, 3'd1);
        8'h46: e = km(4'd5, 3'd2);
        8'h45: e = km(4'd5, 3'd3);
        8'h4E: e = km(4'd5, 3'd4);
        8'h55: e = km(4'd5, 3'd5);
        8'h41: e = km(4'd5, 3'd6);
        8'h49: e = km(4'd5, 3'd7);
        8'h4A: e = km(4'd6, 3'd0);
        8'h4C: e = km(4'd6, 3'd1);
        8'h52: e = km(4'd6, 3'd2);
        8'h54: e = km(4'd6, 3'd3);
        8'h5B: e = km(4'd6, 3'd4);
        8'h5D: e = km(4'd6, 3'd5);
        8'h0E: e = km(4'd6, 3'd6);
        8'h29: e = km(4'd6, 3'd7);
        8'h14: e = km(4'd7, 3'd0);
        8'h76: e = km(4'd7, 3'd1);
        8'h0D: e = km(4'd7, 3'd2);
        8'h66: e = km(4'd7, 3'd3);
        8'h58: e = km(4'd7, 3'd4);
        8'h11: e = km(4'd7, 3'd5);
        8'h05: e = km(4'd8, 3'd0);
        8'h06: e = km(4'd8, 3'd1);
        8'h04: e = km(4'd8, 3'd2);
        8'h5A: e = km(4'd8, 3'd3);
        default: e = '0;
      endcase
    end else begin
      case (c)
        8'h72: e = km(4'd9, 3'd0);
        8'h75: e = km(4'd9, 3'd1);
        8'h6B: e = km(4'd9, 3'd2);
        8'h74: e = km(4'd9, 3'd3);
        8'h71: e = km(4'd9, 3'd4);
        8'h6C: e = km(4'd9, 3'd5);
        default: e = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/lynx_keymap.sv
// Combinational keymap ROM: {ext, scancode} -> Lynx matrix position.
module lynx_keymap
  import lynx_kbd_pkg::*;
(
  input  logic          ext,
  input  logic [7:0]    code,
  output keymap_entry_t entry
);

  assign entry = keymap_lookup(ext, code);

endmodule

// File: rtl/ps2_lynx_matrix.sv
// PS/2 scancode stream to Lynx 10x8 keyboard matrix, with CPU row read port
// and an F12 reset-request pulse.
module ps2_lynx_matrix
  import lynx_kbd_pkg::*;
#(
  parameter int ROWS   = 10,
  parameter int TOUT_W = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       strb,
  input  logic [7:0] code,
  input  logic [3:0] row,
  output logic [7:0] cols,
  output logic       f12
);

  function automatic logic [TOUT_W-1:0] sat_inc(input logic [TOUT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  pfx_state_t        state;
  logic [TOUT_W-1:0] tout;
  logic              clr;
  logic              emit;
  logic              ext_now;
  logic              brk_now;

  logic              vld_p0;
  logic              ext_p0;
  logic              brk_p0;
  logic [7:0]        code_p0;
  keymap_entry_t     ent_p0;

  logic [7:0]        matrix [ROWS];
  logic [7:0]        rd_cols;

  assign clr     = strb && is_clear_code(code);
  assign emit    = strb && !is_clear_code(code) && (code != E0) && (code != F0);
  assign ext_now = (state == EXT) || (state == EXTBRK);
  assign brk_now = (state == BRK) || (state == EXTBRK);

  // Prefix tracking; a fresh byte always takes priority over the timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      tout  <= '0;
    end else begin
      if (strb || state == IDLE) tout <= '0;
      else                       tout <= sat_inc(tout);

      if (strb) begin
        if (clr)              state <= IDLE;
        else if (code == E0)  state <= brk_now ? EXTBRK : EXT;
        else if (code == F0)  state <= ext_now ? EXTBRK : BRK;
        else                  state <= IDLE;
      end else if (state != IDLE && (&tout)) begin
        state <= IDLE;
      end
    end
  end

  // ---- stage p0: event registered for keymap lookup ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= emit;
  end

  always_ff @(posedge clock) begin
    if (emit) begin
      ext_p0  <= ext_now;
      brk_p0  <= brk_now;
      code_p0 <= code;
    end
  end

  lynx_keymap u_keymap (
    .ext   (ext_p0),
    .code  (code_p0),
    .entry (ent_p0)
  );

  // ---- stage p1: matrix update and F12 pulse; a clear beats a pending write ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) matrix[r] <= '0;
      f12 <= 1'b0;
    end else begin
      f12 <= vld_p0 && !ext_p0 && !brk_p0 && (code_p0 == 8'h07);
      if (clr) begin
        for (int r = 0; r < ROWS; r++) matrix[r] <= '0;
      end else if (vld_p0 && ent_p0.valid) begin
        for (int r = 0; r < ROWS; r++)
          if (ent_p0.row == r[3:0]) matrix[r][ent_p0.col] <= ~brk_p0;
      end
    end
  end

  always_comb begin
    rd_cols = 8'hFF;
    for (int r = 0; r < ROWS; r++)
      if (row == r[3:0]) rd_cols = ~matrix[r];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cols <= 8'hFF;
    else       cols <= rd_cols;
  end

endmodule

// File: tb/tb_ps2_lynx_matrix.sv
// Directed bench for ps2_lynx_matrix with an event-queue reference model.
module tb_ps2_lynx_matrix;

  localparam int ROWS   = 10;
  localparam int TOUT_W = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       strb;
  logic [7:0] code;
  logic [3:0] row;
  logic [7:0] cols;
  logic       f12;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  ps2_lynx_matrix #(.ROWS(ROWS), .TOUT_W(TOUT_W)) dut (
    .clock (clock),
    .reset (reset),
    .strb  (strb),
    .code  (code),
    .row   (row),
    .cols  (cols),
    .f12   (f12)
  );

  // Reference model: pending effects carry the cycle in which they become visible.
  typedef struct {
    int due;
    bit clr;
    bit pulse;
    int r;
    int c;
    bit val;
  } item_t;

  item_t      q[$];
  bit         mat [16][8];
  bit         p_ext, p_brk;
  int         last_strb;
  int         cyc = 0;
  logic [7:0] exp_cols = 8'hFF;
  bit         exp_f12 = 1'b0;

  function automatic bit map_key(input bit ext, input logic [7:0] c, output int r, output int col);
    r = 0; col = 0;
    if (!ext && c == 8'h1C)                    begin r = 3; col = 4; return 1; end
    if (!ext && (c == 8'h12 || c == 8'h59))    begin r = 0; col = 0; return 1; end
    if (!ext && c == 8'h5A)                    begin r = 8; col = 3; return 1; end
    if (ext && c == 8'h75)                     begin r = 9; col = 1; return 1; end
    if (ext && c == 8'h6B)                     begin r = 9; col = 2; return 1; end
    return 0;
  endfunction

  initial begin : model
    item_t it;
    int    mr, mc;
    forever begin
      @(posedge clock);
      if (reset) begin
        foreach (mat[i, j]) mat[i][j] = 1'b0;
        q.delete();
        p_ext = 0; p_brk = 0;
        exp_cols = 8'hFF; exp_f12 = 0;
      end else begin
        exp_cols = 8'hFF;
        if (int'(row) < ROWS)
          for (int c = 0; c < 8; c++) if (mat[row][c]) exp_cols[c] = 1'b0;
        if (strb) begin
          if ((p_ext || p_brk) && (cyc - last_strb > (1 << TOUT_W))) begin
            p_ext = 0; p_brk = 0;
          end
          last_strb = cyc;
          if (code == 8'hAA || code == 8'hFC || code == 8'h00 || code == 8'hFF) begin
            it = '{due: cyc + 1, clr: 1, pulse: 0, r: 0, c: 0, val: 0};
            q.push_back(it);
            p_ext = 0; p_brk = 0;
          end else if (code == 8'hE0) begin
            p_ext = 1;
          end else if (code == 8'hF0) begin
            p_brk = 1;
          end else begin
            if (map_key(p_ext, code, mr, mc)) begin
              it = '{due: cyc + 2, clr: 0, pulse: 0, r: mr, c: mc, val: !p_brk};
              q.push_back(it);
            end
            if (!p_ext && !p_brk && code == 8'h07) begin
              it = '{due: cyc + 2, clr: 0, pulse: 1, r: 0, c: 0, val: 0};
              q.push_back(it);
            end
            p_ext = 0; p_brk = 0;
          end
        end
        exp_f12 = 0;
        foreach (q[i])
          if (q[i].due == cyc + 1 && !q[i].clr && !q[i].pulse) mat[q[i].r][q[i].c] = q[i].val;
        foreach (q[i])
          if (q[i].due == cyc + 1 && q[i].clr) foreach (mat[a, b]) mat[a][b] = 1'b0;
        foreach (q[i])
          if (q[i].due == cyc + 1 && q[i].pulse) exp_f12 = 1;
        for (int i = q.size() - 1; i >= 0; i--)
          if (q[i].due <= cyc + 1) q.delete(i);
      end
      cyc++;
    end
  end

  initial begin : compare
    forever begin
      @(negedge clock);
      if (!reset) begin
        tests++;
        if (cols !== exp_cols) begin
          fails++;
          $display("FAIL model_cols cyc=%0d row=%0d got %h expected %h", cyc, row, cols, exp_cols);
        end
        tests++;
        if (f12 !== exp_f12) begin
          fails++;
          $display("FAIL model_f12 cyc=%0d got %b expected %b", cyc, f12, exp_f12);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    strb = 1'b1;
    code = b;
    @(posedge clock);
    #1;
    strb = 1'b0;
  endtask

  task automatic look(input string name, input logic [7:0] exp);
    @(negedge clock);
    check(name, cols, exp);
    @(posedge clock);
    #1;
  endtask

  task automatic count_f12(input string name, input int n, input int exp);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clock);
      cnt += int'(f12);
      @(posedge clock);
      #1;
    end
    check(name, 8'(cnt), 8'(exp));
  endtask

  initial begin : stim
    logic [7:0] specials [3];
    specials = '{8'hFC, 8'h00, 8'hFF};
    reset = 1'b1; strb = 1'b0; code = 8'h00; row = 4'd0;
    idle(2);
    @(negedge clock);
    check("reset_cols", cols, 8'hFF);
    check("reset_f12", {7'b0, f12}, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // Plain make / break
    row = 4'd3;
    send(8'h1C); idle(2); look("a_make", 8'hEF);
    send(8'hF0); send(8'h1C); idle(2); look("a_break", 8'hFF);

    // Extended keys
    row = 4'd9;
    send(8'hE0); send(8'h75); idle(2); look("up_make", 8'hFD);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2); look("up_break", 8'hFF);
    send(8'h75); idle(2); look("plain_75", 8'hFF);

    // Shared shift bit
    row = 4'd0;
    send(8'h12); send(8'h59); send(8'hF0); send(8'h59); idle(2); look("shift_rel", 8'hFF);
    send(8'h12); idle(2); look("shift_repress", 8'hFE);
    send(8'hF0); send(8'h12); idle(2); look("shift_off", 8'hFF);

    // Whole-matrix clears
    row = 4'd3;
    send(8'h1C); send(8'h5A); idle(2); look("a_before_aa", 8'hEF);
    send(8'hAA); idle(1); look("aa_row3", 8'hFF);
    row = 4'd8; idle(1); look("aa_row8", 8'hFF);
    foreach (specials[i]) begin
      send(8'h5A); idle(2); look("enter_make", 8'hF7);
      send(specials[i]); idle(1); look("special_clear", 8'hFF);
    end
    send(8'h5A); send(8'hAA); idle(2); look("clr_wins", 8'hFF);
    row = 4'd12;
    send(8'h5A); idle(2); look("row12", 8'hFF);
    send(8'hF0); send(8'h5A); idle(1);

    // F12 pulse
    send(8'h07);
    @(negedge clock); check("f12_n1", {7'b0, f12}, 8'h00); @(posedge clock); #1;
    @(negedge clock); check("f12_n2", {7'b0, f12}, 8'h01); @(posedge clock); #1;
    @(negedge clock); check("f12_n3", {7'b0, f12}, 8'h00); @(posedge clock); #1;
    send(8'hF0); send(8'h07); count_f12("f12_break", 4, 0);
    send(8'hE0); send(8'h07); count_f12("f12_ext", 4, 0);
    send(8'h07); send(8'h07); count_f12("f12_typematic", 5, 2);

    // Prefix timeout: last cycle that still honours E0, then first that drops it
    row = 4'd9;
    send(8'hE0); idle(15); send(8'h75); idle(2); look("tout_edge_keep", 8'hFD);
    send(8'hE0); send(8'hF0); send(8'h75); idle(2); look("tout_edge_rel", 8'hFF);
    send(8'hE0); idle(16); send(8'h75); idle(2); look("tout_drop", 8'hFF);

    // Reset between prefix and code
    row = 4'd3;
    send(8'h1C); idle(2); look("pre_reset", 8'hEF);
    send(8'hE0);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_cols", cols, 8'hFF);
    check("midreset_f12", {7'b0, f12}, 8'h00);
    @(posedge clock); #1;
    idle(1);
    reset = 1'b0;
    row = 4'd9;
    send(8'h6B); idle(2); look("post_reset_6b", 8'hFF);
    row = 4'd3; idle(1); look("post_reset_row3", 8'hFF);

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_lynx_matrix.md
Name: ps2_lynx_matrix

Overview:
- Consumes the byte stream from the PS/2 receiver (`strb` + `code`) and tracks prefix and release bytes (E0, F0) itself.
- Maps each key event onto the Lynx 10x8 keyboard matrix and holds the matrix state.
- The CPU keyboard port selects a row and reads back 8 active-low column bits.
- Also produces a one-cycle reset-request pulse on F12 press.

Parameters:
- ROWS, 10: number of matrix rows implemented. Rows ROWS..15 read as all-released.
- TOUT_W, 20: width of the prefix timeout counter. A pending prefix is discarded when the counter saturates (2^TOUT_W-1 cycles).

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- strb  in  1  one-cycle pulse: `code` holds a new valid scancode byte
- code  in  8  scancode byte from the PS/2 receiver
- row  in  4  matrix row selected by the CPU port address
- cols  out  8  column bits of the selected row; 0 = pressed; registered
- f12  out  1  one-cycle pulse on F12 press (scancode 07, no E0)

Behaviour:
- Reset (asynchronous, active high):
  - all matrix bits released;
  - prefix state IDLE;
  - `cols` = 8'hFF, `f12` = 0;
  - timeout counter = 0, lookup stage invalid.
- Prefix FSM, advanced only on `strb`:
  - IDLE: E0 -> EXT; F0 -> BRK; other code -> emit event (ext=0, brk=0), stay IDLE.
  - EXT: F0 -> EXTBRK; E0 -> stay EXT; other -> emit (ext=1, brk=0), go IDLE.
  - BRK: E0 -> EXTBRK; F0 -> stay BRK; other -> emit (ext=0, brk=1), go IDLE.
  - EXTBRK: E0/F0 -> stay EXTBRK; other -> emit (ext=1, brk=1), go IDLE.
- Special codes, any state:
  - AA (self-test pass), FC and 00/FF (overrun) clear the whole matrix next cycle and force IDLE. No event is emitted.
- Timeout:
  - The counter clears on every `strb` and counts while the state is not IDLE.
  - At saturation the state forces IDLE; the matrix is unchanged.
- Event pipeline, 2 stages:
  - Cycle N+1 (after `strb` at N): the event {ext, code, brk} is registered into the lookup stage.
  - Cycle N+2: the keymap result {valid, mrow[3:0], mcol[2:0]} updates matrix[mrow][mcol] <= ~brk if valid.
  - Unmapped codes and mrow >= ROWS are ignored.
- Simultaneous events:
  - `strb` arrives every >=1 cycle; the pipeline accepts back-to-back bytes with no stall.
  - A clear (AA/FC/00/FF) in the same cycle as a pending matrix write wins; the matrix ends all released.
- `f12`: asserted in cycle N+2 for exactly one cycle when the event is ext=0, code=07, brk=0. Repeated makes (typematic) pulse again each time.
- Read path:
  - `cols` <= (row < ROWS) ? ~matrix[row] : 8'hFF, registered every cycle.
  - Read latency is 1 cycle from `row`; a matrix write is visible on `cols` 1 cycle after it lands.
- Shift keys: left (12) and right (59) both map to the same matrix bit. That bit is released only when the break for either arrives; no shift-count tracking.
- Reset mid-sequence (e.g. after E0, before the code): everything returns to reset values; the following byte is decoded from IDLE.

Decomposition:
- Package `lynx_kbd_pkg`:
  - prefix constants E0, F0, AA, FC;
  - FSM state enum (IDLE, EXT, BRK, EXTBRK);
  - keymap entry typedef {valid, row[3:0], col[2:0]};
  - the keymap table.
- Required table entries:
  - 1C (A) -> row 3 col 4;
  - 12 and 59 (shifts) -> row 0 col 0;
  - 5A (Enter) -> row 8 col 3;
  - E0 75 (Up) -> row 9 col 1;
  - E0 6B (Left) -> row 9 col 2.
- One sub-module, `lynx_keymap`: combinational ROM {ext, code[7:0]} -> entry, instantiated once in the lookup stage.

Test Plan:
- Reset, then `strb` with 1C; `row`=3 -> `cols`=8'hEF from cycle N+3. Then `strb` F0, `strb` 1C -> `cols` back to 8'hFF.
- `strb` E0, `strb` 75 back-to-back cycles; `row`=9 -> `cols`=8'hFD. Then E0, F0, 75 -> 8'hFF. Plain 75 (no E0) leaves row 9 unaffected.
- Press 12 and 59, release 59; `row`=0 -> `cols`=8'hFF (bit 0 released). Re-press 12 -> 8'hFE.
- Press 1C and 5A, then `strb` AA -> rows 3 and 8 read 8'hFF. `row`=12 always reads 8'hFF.
- `strb` 07 -> `f12` high exactly one cycle at N+2. F0 07 -> no pulse. E0 07 -> no pulse.
- `strb` E0, then wait 2^TOUT_W cycles (TOUT_W=4 in sim), then `strb` 75 -> no row-9 change. Assert reset between E0 and 6B -> matrix all FF, following 6B unmapped, no change.
